fft_bitrev_reorder: RTL and testbench



---
 rtl/fft_bitrev_reorder_pkg.sv | 55 +++++
 rtl/fft_reorder_bank.sv | 64 ++++++
 rtl/fft_bitrev_reorder.sv | 119 +++++++++++
 tb/tb_fft_bitrev_reorder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_bitrev_reorder_pkg.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder_pkg
// Shared FFT definitions used by the reorder buffer and its bank sub-module.
//   - bank_state_e   : per-bank occupancy flag (EMPTY / FULL)
//   - bitrev()       : reverses the low log2n bits of an index
//   - fire()         : val/rdy handshake completion
//   - sample packing : re in the upper W/2 bits, im in the lower W/2 bits
// -----------------------------------------------------------------------------
package fft_bitrev_reorder_pkg;

  // Widest frame index supported by the helpers (N up to 1024).
  localparam int unsigned FFT_MAX_LOG2N = 10;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Bit-reverse the low log2n bits of idx; upper result bits are zero.
  // Shifting the LSB out of a temporary into the result reverses the order
  // without any variable bit-select.
  function automatic logic [FFT_MAX_LOG2N-1:0] bitrev(
    input logic [FFT_MAX_LOG2N-1:0] idx,
    input int unsigned              log2n
  );
    logic [FFT_MAX_LOG2N-1:0] r;
    logic [FFT_MAX_LOG2N-1:0] t;
    r = '0;
    t = idx;
    for (int unsigned i = 0; i < FFT_MAX_LOG2N; i++) begin
      if (i < log2n) begin
        r = {r[FFT_MAX_LOG2N-2:0], t[0]};
        t = t >> 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // A val/rdy beat transfers when both sides agree in the same cycle.
  function automatic logic fire(input logic val, input logic rdy);
    return val & rdy;
  endfunction

  // Sample packing: re occupies [w-1:w/2], im occupies [w/2-1:0].
  function automatic int unsigned sample_re_lsb(input int unsigned w);
    return w / 2;
  endfunction

  function automatic int unsigned sample_im_msb(input int unsigned w);
    return (w / 2) - 1;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// -----------------------------------------------------------------------------
// fft_reorder_bank
// One ping-pong bank: a depth-N 1-write/1-read RAM (registered write,
// combinational read, contents cleared to 0 on reset) plus its EMPTY/FULL flag.
// Ports:
//   clk, reset_p     : clock, synchronous active-high reset
//   i_set_full       : mark bank FULL on this edge
//   i_set_empty      : mark bank EMPTY on this edge
//   i_wen, i_waddr, i_wdata : write port
//   i_raddr, o_rdata : combinational read port
//   o_full           : bank currently FULL
// -----------------------------------------------------------------------------
module fft_reorder_bank
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned LOG2N = 3
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             i_set_full,
  input  logic             i_set_empty,
  input  logic             i_wen,
  input  logic [LOG2N-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic [LOG2N-1:0] i_raddr,
  output logic [W-1:0]     o_rdata,
  output logic             o_full
);

  localparam int unsigned N = 2 ** LOG2N;

  logic [W-1:0] r_mem [N];
  bank_state_e  r_state;

  // RAM array: cleared on reset, otherwise written on a write strobe.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      for (int i = 0; i < N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wen) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Occupancy flag: the top never fills and drains the same bank at once,
  // so set_full and set_empty are mutually exclusive for a given bank.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_state <= BANK_EMPTY;
    end else if (i_set_full) begin
      r_state <= BANK_FULL;
    end else if (i_set_empty) begin
      r_state <= BANK_EMPTY;
    end else begin
      r_state <= r_state;
    end
  end

  assign o_rdata = r_mem[i_raddr];
  assign o_full  = (r_state == BANK_FULL);

endmodule

// File: rtl/fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// fft_bitrev_reorder
// Ping-pong reorder buffer: accepts N = 2^LOG2N samples in natural order and
// emits each frame in bit-reversed index order. One bank fills while the other
// drains, so a continuous stream flows at one sample per cycle.
// Ports:
//   clk, reset_p       : clock, synchronous active-high reset
//   in_val/in_rdy/in_bits    : natural-order input stream
//   out_val/out_rdy/out_bits : bit-reversed output stream
//   out_last           : high with the final sample of each frame
// -----------------------------------------------------------------------------
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned LOG2N = 3
) (
  input  logic         clk,
  input  logic         reset_p,
  input  logic         in_val,
  output logic         in_rdy,
  input  logic [W-1:0] in_bits,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [W-1:0] out_bits,
  output logic         out_last
);

  localparam int unsigned      N        = 2 ** LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

  logic             r_wr_bank;
  logic             r_rd_bank;
  logic [LOG2N-1:0] r_wr_cnt;
  logic [LOG2N-1:0] r_rd_cnt;

  logic [1:0]       w_full;
  logic [1:0]       w_wen;
  logic [1:0]       w_set_full;
  logic [1:0]       w_set_empty;
  logic [W-1:0]     w_rdata [2];
  logic [LOG2N-1:0] w_raddr;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_wr_last;
  logic             w_rd_last;

  assign in_rdy     = !reset_p && !w_full[r_wr_bank];
  assign out_val    = !reset_p &&  w_full[r_rd_bank];
  assign w_in_fire  = fire(in_val, in_rdy);
  assign w_out_fire = fire(out_val, out_rdy);
  assign w_wr_last  = (r_wr_cnt == CNT_LAST);
  assign w_rd_last  = (r_rd_cnt == CNT_LAST);

  assign w_raddr  = LOG2N'(bitrev(FFT_MAX_LOG2N'(r_rd_cnt), LOG2N));
  assign out_bits = w_rdata[r_rd_bank];
  assign out_last = out_val && w_rd_last;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign w_wen[b]       = w_in_fire  && (r_wr_bank == 1'(b));
    assign w_set_full[b]  = w_wen[b]   && w_wr_last;
    assign w_set_empty[b] = w_out_fire && (r_rd_bank == 1'(b)) && w_rd_last;

    fft_reorder_bank #(
      .W     (W),
      .LOG2N (LOG2N)
    ) u_bank (
      .clk         (clk),
      .reset_p     (reset_p),
      .i_set_full  (w_set_full[b]),
      .i_set_empty (w_set_empty[b]),
      .i_wen       (w_wen[b]),
      .i_waddr     (r_wr_cnt),
      .i_wdata     (in_bits),
      .i_raddr     (w_raddr),
      .o_rdata     (w_rdata[b]),
      .o_full      (w_full[b])
    );
  end

  // Write side: advance the fill index, switch banks after the last sample.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_in_fire) begin
      if (w_wr_last) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= ~r_wr_bank;
      end else begin
        r_wr_cnt  <= r_wr_cnt + 1'b1;
        r_wr_bank <= r_wr_bank;
      end
    end else begin
      r_wr_cnt  <= r_wr_cnt;
      r_wr_bank <= r_wr_bank;
    end
  end

  // Read side: advance the drain index, switch banks after the last sample.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_rd_cnt  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_out_fire) begin
      if (w_rd_last) begin
        r_rd_cnt  <= '0;
        r_rd_bank <= ~r_rd_bank;
      end else begin
        r_rd_cnt  <= r_rd_cnt + 1'b1;
        r_rd_bank <= r_rd_bank;
      end
    end else begin
      r_rd_cnt  <= r_rd_cnt;
      r_rd_bank <= r_rd_bank;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_bitrev_reorder
// Directed bench for the bit-reversal reorder buffer: an N=8 instance driven
// from a vector table and hand-written sequences, plus an N=2 instance.
// -----------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

  logic       clk;
  logic       reset_p;
  logic       in_val, in_rdy, out_val, out_rdy, out_last;
  logic [7:0] in_bits, out_bits;
  logic       t_in_val, t_in_rdy, t_out_val, t_out_rdy, t_out_last;
  logic [7:0] t_in_bits, t_out_bits;

  int n_cmp;
  int n_bad;

  fft_bitrev_reorder #(.W(8), .LOG2N(3)) dut (
    .clk(clk), .reset_p(reset_p),
    .in_val(in_val), .in_rdy(in_rdy), .in_bits(in_bits),
    .out_val(out_val), .out_rdy(out_rdy), .out_bits(out_bits), .out_last(out_last)
  );

  fft_bitrev_reorder #(.W(8), .LOG2N(1)) dut1 (
    .clk(clk), .reset_p(reset_p),
    .in_val(t_in_val), .in_rdy(t_in_rdy), .in_bits(t_in_bits),
    .out_val(t_out_val), .out_rdy(t_out_rdy), .out_bits(t_out_bits), .out_last(t_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] ib;
    logic       ordy;
    logic       e_irdy;
    logic       e_oval;
    logic [7:0] e_obits;
    logic       e_olast;
  } vec_t;

  vec_t tbl [17];

  function automatic int tb_brev(input int v, input int bits);
    int r;
    r = 0;
    for (int i = 0; i < bits; i++) begin
      if ((v >> i) & 1) r = r | (1 << (bits - 1 - i));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_p = 1'b1; in_val = 1'b0; out_rdy = 1'b0; t_in_val = 1'b0; t_out_rdy = 1'b0;
    step();
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_last", out_last, 0);
    reset_p = 1'b0;
    #1;
    chk("rst_out_bits", out_bits, 0);
    chk("post_rst_in_rdy", in_rdy, 1);
  endtask

  initial begin
    int accepted, got, lasts, in_sent, f, j;
    logic [7:0] q[$];
    n_cmp = 0; n_bad = 0;
    reset_p = 1'b1; in_val = 1'b0; in_bits = '0; out_rdy = 1'b0;
    t_in_val = 1'b0; t_in_bits = '0; t_out_rdy = 1'b0;

    // Table: one frame 0..7 in, then drained in bit-reversed order.
    for (int c = 0; c < 17; c++) begin
      tbl[c].iv      = (c < 8);
      tbl[c].ib      = 8'(c);
      tbl[c].ordy    = 1'b1;
      tbl[c].e_irdy  = 1'b1;
      tbl[c].e_oval  = (c >= 8 && c < 16);
      tbl[c].e_obits = (c >= 8 && c < 16) ? 8'(tb_brev(c - 8, 3)) : 8'd0;
      tbl[c].e_olast = (c == 15);
    end

    do_reset();
    for (int c = 0; c < 17; c++) begin
      in_val = tbl[c].iv; in_bits = tbl[c].ib; out_rdy = tbl[c].ordy;
      #1;
      chk($sformatf("tbl%0d_in_rdy", c), in_rdy, tbl[c].e_irdy);
      chk($sformatf("tbl%0d_out_val", c), out_val, tbl[c].e_oval);
      chk($sformatf("tbl%0d_out_bits", c), out_bits, tbl[c].e_obits);
      chk($sformatf("tbl%0d_out_last", c), out_last, tbl[c].e_olast);
      step();
    end

    // Continuous stream of three frames: no bubbles on either side.
    do_reset();
    out_rdy = 1'b1;
    for (int c = 0; c < 34; c++) begin
      in_val = (c < 24); in_bits = 8'(c);
      #1;
      if (c < 24) chk("stream_in_rdy", in_rdy, 1);
      if (c >= 8 && c < 32) begin
        f = (c - 8) / 8; j = (c - 8) % 8;
        chk("stream_out_val", out_val, 1);
        chk("stream_out_bits", out_bits, 32'(f * 8 + tb_brev(j, 3)));
        chk("stream_out_last", out_last, 32'(j == 7));
      end else begin
        chk("stream_idle_out_val", out_val, 0);
      end
      step();
    end

    // Full backpressure: two frames buffered, then the input stalls.
    do_reset();
    out_rdy = 1'b0; accepted = 0;
    for (int k = 0; k < 24; k++) begin
      in_val = 1'b1; in_bits = 8'(k);
      #1;
      chk("bp_in_rdy", in_rdy, 32'(k < 16));
      if (in_rdy) accepted++;
      if (k >= 8) begin
        chk("bp_out_val", out_val, 1);
        chk("bp_out_bits_hold", out_bits, 0);
        chk("bp_out_last_hold", out_last, 0);
      end
      step();
    end
    chk("bp_accepted", accepted, 16);
    in_val = 1'b0; out_rdy = 1'b1;
    for (int d = 0; d < 16; d++) begin
      #1;
      chk("drain_in_rdy", in_rdy, 32'(d >= 8));
      chk("drain_out_val", out_val, 1);
      chk("drain_out_bits", out_bits, 32'((d / 8) * 8 + tb_brev(d % 8, 3)));
      step();
    end
    chk("drain_done_out_val", out_val, 0);

    // Reset during a partial fill, then again during a drain.
    do_reset();
    out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_val = 1'b1; in_bits = 8'(8'h50 + k);
      step();
    end
    reset_p = 1'b1;
    step();
    chk("midfill_rst_in_rdy", in_rdy, 0);
    chk("midfill_rst_out_val", out_val, 0);
    reset_p = 1'b0;
    #1;
    chk("midfill_rel_in_rdy", in_rdy, 1);
    chk("midfill_rel_out_val", out_val, 0);
    for (int k = 0; k < 8; k++) begin
      in_val = 1'b1; in_bits = 8'(k);
      step();
    end
    in_val = 1'b0; out_rdy = 1'b1;
    for (int d = 0; d < 3; d++) begin
      #1;
      chk("middrain_out_val", out_val, 1);
      chk("middrain_out_bits", out_bits, 32'(tb_brev(d, 3)));
      step();
    end
    reset_p = 1'b1;
    step();
    chk("middrain_rst_in_rdy", in_rdy, 0);
    chk("middrain_rst_out_val", out_val, 0);
    reset_p = 1'b0;
    #1;
    chk("middrain_rel_out_bits", out_bits, 0);
    for (int k = 0; k < 8; k++) begin
      in_val = 1'b1; in_bits = 8'(100 + k);
      #1;
      chk("fresh_fill_out_val", out_val, 0);
      step();
    end
    in_val = 1'b0;
    for (int d = 0; d < 8; d++) begin
      #1;
      chk("fresh_out_val", out_val, 1);
      chk("fresh_out_bits", out_bits, 32'(100 + tb_brev(d, 3)));
      step();
    end

    // Random stalls on both sides over 20 frames against a scoreboard.
    do_reset();
    in_sent = 0; got = 0; lasts = 0;
    for (int cyc = 0; cyc < 4000 && got < 160; cyc++) begin
      in_val  = (in_sent < 160) && ($urandom_range(0, 1) == 1);
      in_bits = 8'($urandom_range(0, 255));
      out_rdy = ($urandom_range(0, 1) == 1);
      #1;
      if (in_val && in_rdy) begin
        q.push_back(in_bits);
        in_sent++;
      end
      if (out_val && out_rdy) begin
        f = got / 8; j = got % 8;
        if (f * 8 + 8 <= q.size())
          chk("rand_out_bits", out_bits, 32'(q[f * 8 + tb_brev(j, 3)]));
        else
          chk("rand_out_early", 1, 0);
        chk("rand_out_last", out_last, 32'(j == 7));
        if (out_last) lasts++;
        got++;
      end
      step();
    end
    chk("rand_out_count", got, 160);
    chk("rand_last_count", lasts, 20);
    in_val = 1'b0; out_rdy = 1'b0;

    // N=2 instance: bit reversal of a 1-bit index is the identity.
    t_out_rdy = 1'b1;
    t_in_val = 1'b1; t_in_bits = 8'hA5;
    #1;
    chk("n2_in_rdy0", t_in_rdy, 1);
    chk("n2_out_val0", t_out_val, 0);
    step();
    t_in_bits = 8'h3C;
    #1;
    chk("n2_in_rdy1", t_in_rdy, 1);
    step();
    t_in_val = 1'b0;
    #1;
    chk("n2_out_val_a", t_out_val, 1);
    chk("n2_out_bits_a", t_out_bits, 32'h0A5);
    chk("n2_out_last_a", t_out_last, 0);
    step();
    chk("n2_out_val_b", t_out_val, 1);
    chk("n2_out_bits_b", t_out_bits, 32'h03C);
    chk("n2_out_last_b", t_out_last, 1);
    step();
    chk("n2_out_val_done", t_out_val, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
